// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequences the RV32I MEM-stage data-memory port for loads and stores.
//   An access is accepted in IDLE, its address/size/lanes/data are registered,
//   then a req/gnt handshake is run (REQ), a read waits for rvalid (WAIT),
//   and a single DONE cycle releases the pipeline. Misaligned or illegal
//   accesses are rejected in IDLE with a one-cycle misalign_fault pulse and
//   never reach memory.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   mem_read/write  decoded load/store strobes
//   funct3          access size/sign (B, H, W, BU, HU)
//   addr, wdata     byte address and right-justified store data
//   stall           freeze the IF/ID/EX/MEM pipeline registers
//   rdata_out       extended load result, rdata_valid pulses in DONE for loads
//   misalign_fault  one-cycle pulse when an access is rejected
//   dm_req/we/addr/wstrb/wdata  request side of the memory port (registered)
//   dm_gnt, dm_rvalid, dm_rdata response side of the memory port
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        misalign_fault,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  f3_reg;
  logic [1:0]  off_reg;

  logic        access;
  logic        both;
  logic        size_h;
  logic        size_w;
  logic        bad_f3;
  logic        bad_store;
  logic        bad_align;
  logic        req_legal;
  logic        req_fault;
  logic [3:0]  strb_next;
  logic [31:0] wdata_lane;
  logic [31:0] load_shift;
  logic [31:0] load_ext;

  // ---------------- access classification (IDLE inputs) ----------------
  always_comb begin
    access    = mem_read ^ mem_write;
    both      = mem_read & mem_write;
    size_h    = (funct3[1:0] == 2'b01);
    size_w    = (funct3[1:0] == 2'b10);
    // 011, 110, 111 are not load/store sizes in RV32I
    bad_f3    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    // unsigned variants only exist for loads
    bad_store = mem_write & funct3[2];
    bad_align = (size_h & addr[0]) | (size_w & (addr[1:0] != 2'b00));
    req_legal = access & ~(bad_f3 | bad_store | bad_align);
    req_fault = both | (access & ~req_legal);
  end

  // ---------------- store lane placement ----------------
  always_comb begin
    strb_next  = 4'b0000;
    wdata_lane = wdata;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          strb_next  = 4'b0001 << addr[1:0];
          wdata_lane = {4{wdata[7:0]}};
        end
        2'b01: begin
          strb_next  = 4'b0011 << addr[1:0];
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          strb_next  = 4'b1111;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  // ---------------- load extraction from the registered offset ----------------
  always_comb begin
    load_shift = dm_rdata >> {off_reg, 3'b000};
    case (f3_reg)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b100:  load_ext = {24'd0, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b101:  load_ext = {16'd0, load_shift[15:0]};
      default: load_ext = dm_rdata;
    endcase
  end

  // ---------------- FSM next state and outputs ----------------
  always_comb begin
    state_next     = state;
    stall          = 1'b0;
    misalign_fault = 1'b0;
    dm_req         = 1'b0;
    rdata_valid    = 1'b0;
    case (state)
      IDLE: begin
        // stall/fault are combinational from the inputs so the pipeline
        // freezes in the same cycle the access is presented
        stall          = req_legal & ~rst;
        misalign_fault = req_fault & ~rst;
        if (req_legal) state_next = REQ;
      end
      REQ: begin
        stall  = 1'b1;
        dm_req = 1'b1;
        if (dm_gnt) state_next = dm_we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dm_rvalid) state_next = DONE;
      end
      DONE: begin
        rdata_valid = ~dm_we;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f3_reg    <= 3'b000;
      off_reg   <= 2'b00;
      dm_we     <= 1'b0;
      dm_addr   <= 32'd0;
      dm_wstrb  <= 4'b0000;
      dm_wdata  <= 32'd0;
      rdata_out <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_legal) begin
        f3_reg   <= funct3;
        off_reg  <= addr[1:0];
        dm_we    <= mem_write;
        dm_addr  <= {addr[31:2], 2'b00};
        dm_wstrb <= strb_next;
        dm_wdata <= wdata_lane;
      end
      if (state == WAIT && dm_rvalid) begin
        rdata_out <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by
// random loads/stores, compared against a byte-addressed memory model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, misalign_fault;
  logic [31:0] rdata_out;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  logic [31:0] last_rd = 32'd0;
  logic [31:0] mem [int unsigned];

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .misalign_fault(misalign_fault),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},   {31'd0, stall},          32'd0);
    check({tag, ".rvalid"},  {31'd0, rdata_valid},    32'd0);
    check({tag, ".fault"},   {31'd0, misalign_fault}, 32'd0);
    check({tag, ".req"},     {31'd0, dm_req},         32'd0);
    check({tag, ".we"},      {31'd0, dm_we},          32'd0);
    check({tag, ".rdata"},   rdata_out,               32'd0);
    check({tag, ".addr"},    dm_addr,                 32'd0);
    check({tag, ".wstrb"},   {28'd0, dm_wstrb},       32'd0);
    check({tag, ".wdata"},   dm_wdata,                32'd0);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    if (!mem.exists(waddr)) mem[waddr] = $urandom;
    return mem[waddr];
  endfunction

  // One access through the port. g = cycles gnt stays low in REQ,
  // r = cycles rvalid stays low in WAIT.
  task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int g, input int r);
    bit          legal;
    int          nbytes, o, stall_seen, stall_exp;
    logic [31:0] waddr, exp_strb, exp_wd, word, sh, mask, exp_rd;

    nbytes = 1 << f3[1:0];
    o      = int'(a % 4);
    waddr  = a - (a % 4);
    legal  = !(rd && wr) && !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)
             && !(wr && f3[2]) && ((a % nbytes) == 0);
    exp_strb = wr ? (((32'd1 << nbytes) - 1) << o) : 32'd0;
    case (nbytes)
      1:       exp_wd = {24'd0, wd[7:0]}  * 32'h01010101;
      2:       exp_wd = {16'd0, wd[15:0]} * 32'h00010001;
      default: exp_wd = wd;
    endcase
    n_txn++;

    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    #1;
    check("idle.rdata_hold", rdata_out, last_rd);
    check("idle.req", {31'd0, dm_req}, 32'd0);

    if (!legal) begin
      check("fault.pulse", {31'd0, misalign_fault}, 32'd1);
      check("fault.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check("fault.after_req",   {31'd0, dm_req}, 32'd0);
      check("fault.after_pulse", {31'd0, misalign_fault}, 32'd0);
      $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%08h -> fault", n_txn, rd, wr, f3, a);
      return;
    end

    check("idle.nofault", {31'd0, misalign_fault}, 32'd0);
    stall_seen = int'(stall);

    for (int i = 0; i <= g; i++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      dm_gnt = (i == g);
      dm_rvalid = rd ? 1'($urandom % 2) : 1'b0;
      dm_rdata  = $urandom;
      #1;
      stall_seen += int'(stall);
      check("req.req",   {31'd0, dm_req}, 32'd1);
      check("req.we",    {31'd0, dm_we}, {31'd0, wr});
      check("req.addr",  dm_addr, waddr);
      check("req.wstrb", {28'd0, dm_wstrb}, exp_strb);
      if (wr) check("req.wdata", dm_wdata, exp_wd);
    end

    if (rd) begin
      word   = mem_word(waddr);
      sh     = word >> (8 * o);
      mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
      exp_rd = sh & mask;
      if (!f3[2] && nbytes < 4 && exp_rd[8 * nbytes - 1]) exp_rd = exp_rd | ~mask;
      for (int j = 0; j <= r; j++) begin
        @(negedge clk);
        dm_gnt    = 1'b0;
        dm_rvalid = (j == r);
        dm_rdata  = (j == r) ? word : $urandom;
        #1;
        stall_seen += int'(stall);
        check("wait.req", {31'd0, dm_req}, 32'd0);
      end
    end else begin
      word = mem_word(waddr);
      for (int k = 0; k < 4; k++)
        if (exp_strb[k]) word[8 * k +: 8] = exp_wd[8 * k +: 8];
      mem[waddr] = word;
      exp_rd = last_rd;
    end

    // DONE: a stray rvalid here must be ignored
    @(negedge clk);
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = $urandom;
    #1;
    check("done.stall",  {31'd0, stall}, 32'd0);
    check("done.req",    {31'd0, dm_req}, 32'd0);
    check("done.rvalid", {31'd0, rdata_valid}, {31'd0, rd});
    check("done.rdata",  rdata_out, exp_rd);
    last_rd   = exp_rd;
    stall_exp = 1 + (g + 1) + (rd ? (r + 1) : 0);
    check("stall_cycles", stall_seen, stall_exp);
    $display("txn %0d rd=%0b wr=%0b f3=%0d addr=%08h wd=%08h g=%0d r=%0d stall=%0d rdata=%08h",
             n_txn, rd, wr, f3, a, wd, g, r, stall_seen, rdata_out);
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT, then a late rvalid must be ignored
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
    @(negedge clk);
    mem_read = 1'b0; dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    #1;
    check("wait.stall_pre_rst", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dm_rvalid = 1'b0;
    #1;
    check("postrst.rvalid", {31'd0, rdata_valid}, 32'd0);
    check("postrst.rdata",  rdata_out, 32'd0);
    check("postrst.stall",  {31'd0, stall}, 32'd0);
    $display("txn reset-during-wait done");

    // Directed scenarios
    do_txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0);   // SB
    check("sb.wstrb_last", {28'd0, dm_wstrb}, 32'h8);
    check("sb.wdata_last", dm_wdata, 32'hA5A5_A5A5);
    mem[32'h2000] = 32'h1234_8056;
    do_txn(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 3, 1);            // LB
    check("lb.result", rdata_out, 32'hFFFF_FF80);
    mem[32'h2000] = 32'h8001_FFFF;
    do_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 0);            // LHU
    check("lhu.result", rdata_out, 32'h0000_8001);
    do_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 1, 2);            // LH
    check("lh.result", rdata_out, 32'hFFFF_8001);
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'd0, 0, 0);            // LW misaligned
    do_txn(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h1234, 0, 0);         // SH misaligned
    do_txn(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'd0, 0, 0);            // both strobes
    do_txn(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 0, 0);    // SW
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 0, 0);            // LW back-to-back
    check("sw_lw.result", rdata_out, 32'hCAFE_F00D);

    // Random mix over a small window so loads hit earlier stores
    for (int t = 0; t < 80; t++) begin
      bit rd, wr;
      int sel;
      sel = $urandom_range(0, 9);
      rd  = (sel < 5) || (sel == 9);
      wr  = (sel >= 5);
      do_txn(rd, wr, 3'($urandom_range(0, 7)),
             32'h0000_4000 + 32'($urandom_range(0, 31)),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    dm_rvalid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
